// File: rtl/stage_step_gate.sv
// rtl/stage_step_gate.sv - per-stage ready release gate with bypass, single-step and breakpoint modes
// Holds FSM ready pulses per stage and releases them on step commands; also merges stage done pulses.
module stage_step_gate #(
  parameter int NUM_STAGES = 9,
  parameter int CNT_W      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            mode,
  input  logic [NUM_STAGES-1:0] bp_mask,
  input  logic [NUM_STAGES-1:0] ready_in,
  input  logic [NUM_STAGES-1:0] stage_done,
  input  logic                  step_go,
  input  logic                  step_all,
  input  logic                  clr_status,
  output logic [NUM_STAGES-1:0] ready_out,
  output logic [NUM_STAGES-1:0] pending,
  output logic                  halted,
  output logic                  done_any,
  output logic                  overflow,
  output logic [CNT_W-1:0]      step_count
);

  localparam int SUM_W = CNT_W + 6;

  logic [NUM_STAGES-1:0] gateMask;
  logic [NUM_STAGES-1:0] held;
  logic [NUM_STAGES-1:0] lowestHeld;
  logic [NUM_STAGES-1:0] relSel;
  logic [NUM_STAGES-1:0] relVec;
  logic [NUM_STAGES-1:0] pendingNext;
  logic [NUM_STAGES-1:0] ovfHit;
  logic [5:0]            relCount;
  logic [SUM_W-1:0]      countSum;
  logic [CNT_W-1:0]      countNext;

  always_comb begin
    gateMask = '1;
    case (mode)
      2'b00:   gateMask = '0;
      2'b10:   gateMask = bp_mask;
      default: gateMask = '1;
    endcase

    held = pending | (ready_in & gateMask);

    // Scan from the top so the last hit left standing is the lowest index.
    lowestHeld = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (held[i]) begin
        lowestHeld    = '0;
        lowestHeld[i] = 1'b1;
      end
    end

    relSel = '0;
    if (mode == 2'b00)  relSel = pending;
    else if (step_all)  relSel = held;
    else if (step_go)   relSel = lowestHeld;

    relVec      = relSel | (ready_in & ~gateMask);
    pendingNext = held & ~relSel;
    ovfHit      = ready_in & pending & gateMask & ~relSel;

    relCount = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      relCount = relCount + {5'b0, relVec[i]};
    end

    countSum = {6'b0, step_count} + {{CNT_W{1'b0}}, relCount};
    if (|countSum[SUM_W-1:CNT_W]) countNext = '1;
    else                          countNext = countSum[CNT_W-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ready_out  <= '0;
      pending    <= '0;
      halted     <= 1'b0;
      done_any   <= 1'b0;
      overflow   <= 1'b0;
      step_count <= '0;
    end else begin
      ready_out  <= relVec;
      pending    <= pendingNext;
      halted     <= |pendingNext;
      done_any   <= |stage_done;
      // A fresh overflow outranks a same-cycle clear.
      overflow   <= (|ovfHit) | (overflow & ~clr_status);
      step_count <= clr_status ? '0 : countNext;
    end
  end

endmodule

// File: tb/tb_stage_step_gate.sv
// tb/tb_stage_step_gate.sv - self-checking bench for stage_step_gate
// Directed vector table, hand sequences and random stimulus against a per-stage reference model.
module tb_stage_step_gate;

  logic       clock;
  logic       reset;
  logic [1:0] mode;
  logic [8:0] bp_mask, ready_in, stage_done;
  logic       step_go, step_all, clr_status;
  logic [8:0] ready_out, pending;
  logic       halted, done_any, overflow;
  logic [15:0] step_count;
  logic [8:0] readyOutS, pendingS;
  logic       haltedS, doneAnyS, overflowS;
  logic [1:0] stepCountS;

  stage_step_gate #(.NUM_STAGES(9), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .mode(mode), .bp_mask(bp_mask),
    .ready_in(ready_in), .stage_done(stage_done), .step_go(step_go),
    .step_all(step_all), .clr_status(clr_status), .ready_out(ready_out),
    .pending(pending), .halted(halted), .done_any(done_any),
    .overflow(overflow), .step_count(step_count)
  );

  stage_step_gate #(.NUM_STAGES(9), .CNT_W(2)) dutSmall (
    .clock(clock), .reset(reset), .mode(mode), .bp_mask(bp_mask),
    .ready_in(ready_in), .stage_done(stage_done), .step_go(step_go),
    .step_all(step_all), .clr_status(clr_status), .ready_out(readyOutS),
    .pending(pendingS), .halted(haltedS), .done_any(doneAnyS),
    .overflow(overflowS), .step_count(stepCountS)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  bit       mPend[9];
  bit [8:0] mOut;
  bit       mHalt, mDone, mOvf;
  int       mCount, mSmall;

  typedef struct {
    logic [1:0] mode;
    logic [8:0] bp;
    logic [8:0] rdy;
    logic       go;
    logic       all;
    logic       clr;
    logic [8:0] expOut;
    logic [8:0] expPend;
    logic       expHalt;
    logic       expOvf;
  } vecT;

  vecT vecs[$];

  function automatic vecT mk(logic [1:0] m, logic [8:0] bp, logic [8:0] rdy, logic go,
                             logic all, logic clr, logic [8:0] eo, logic [8:0] ep,
                             logic eh, logic ev);
    vecT v;
    v.mode = m; v.bp = bp; v.rdy = rdy; v.go = go; v.all = all; v.clr = clr;
    v.expOut = eo; v.expPend = ep; v.expHalt = eh; v.expOvf = ev;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelStep();
    bit g[9], hd[9], sel[9];
    bit ovfNew;
    bit anyPend;
    int first;
    int n;
    if (reset) begin
      for (int i = 0; i < 9; i++) mPend[i] = 0;
      mOut = '0; mHalt = 0; mDone = 0; mOvf = 0; mCount = 0; mSmall = 0;
    end else begin
      first = -1; n = 0; ovfNew = 0; anyPend = 0;
      for (int i = 0; i < 9; i++) begin
        g[i]  = (mode == 2'd0) ? 1'b0 : (mode == 2'd2) ? bp_mask[i] : 1'b1;
        hd[i] = mPend[i] || (ready_in[i] && g[i]);
      end
      for (int i = 0; i < 9; i++) begin
        sel[i] = 0;
        if (mode == 2'd0) sel[i] = mPend[i];
        else if (step_all) sel[i] = hd[i];
        else if (step_go && first < 0 && hd[i]) begin
          sel[i] = 1;
          first = i;
        end
      end
      for (int i = 0; i < 9; i++) begin
        mOut[i] = sel[i] || (ready_in[i] && !g[i]);
        if (mOut[i]) n++;
        if (ready_in[i] && mPend[i] && g[i] && !sel[i]) ovfNew = 1;
        mPend[i] = hd[i] && !sel[i];
        if (mPend[i]) anyPend = 1;
      end
      mHalt = anyPend;
      mDone = (stage_done != 0);
      mOvf  = ovfNew ? 1'b1 : (clr_status ? 1'b0 : mOvf);
      if (clr_status) begin
        mCount = 0; mSmall = 0;
      end else begin
        mCount = (mCount + n > 65535) ? 65535 : mCount + n;
        mSmall = (mSmall + n > 3) ? 3 : mSmall + n;
      end
    end
  endtask

  task automatic checkModel();
    logic [8:0] pv;
    for (int i = 0; i < 9; i++) pv[i] = mPend[i];
    chk("ready_out", 32'(ready_out), 32'(mOut));
    chk("pending", 32'(pending), 32'(pv));
    chk("halted", 32'(halted), 32'(mHalt));
    chk("done_any", 32'(done_any), 32'(mDone));
    chk("overflow", 32'(overflow), 32'(mOvf));
    chk("step_count", 32'(step_count), 32'(mCount));
    chk("step_count_small", 32'(stepCountS), 32'(mSmall));
  endtask

  task automatic doCycle();
    modelStep();
    @(posedge clock);
    #1;
    checkModel();
  endtask

  task automatic setIn(logic [1:0] m, logic [8:0] bp, logic [8:0] rdy, logic go,
                       logic all, logic clr);
    mode = m; bp_mask = bp; ready_in = rdy; step_go = go; step_all = all;
    clr_status = clr; stage_done = '0;
  endtask

  initial begin
    reset = 1'b1;
    setIn(2'd0, '0, '0, 0, 0, 0);
    repeat (2) doCycle();
    chk("reset_ready_out", 32'(ready_out), 0);
    chk("reset_step_count", 32'(step_count), 0);
    reset = 1'b0;

    //                mode  bp      rdy     go all clr  out     pend   halt ovf
    vecs.push_back(mk(2'd0, 9'h000, 9'h004, 0, 0, 0, 9'h004, 9'h000, 0, 0));
    vecs.push_back(mk(2'd0, 9'h000, 9'h000, 0, 0, 0, 9'h000, 9'h000, 0, 0));
    vecs.push_back(mk(2'd1, 9'h000, 9'h001, 0, 0, 0, 9'h000, 9'h001, 1, 0));
    vecs.push_back(mk(2'd1, 9'h000, 9'h000, 0, 0, 0, 9'h000, 9'h001, 1, 0));
    vecs.push_back(mk(2'd1, 9'h000, 9'h000, 1, 0, 0, 9'h001, 9'h000, 0, 0));
    vecs.push_back(mk(2'd1, 9'h000, 9'h10A, 0, 0, 0, 9'h000, 9'h10A, 1, 0));
    vecs.push_back(mk(2'd1, 9'h000, 9'h000, 1, 0, 0, 9'h002, 9'h108, 1, 0));
    vecs.push_back(mk(2'd1, 9'h000, 9'h000, 1, 0, 0, 9'h008, 9'h100, 1, 0));
    vecs.push_back(mk(2'd1, 9'h000, 9'h000, 1, 0, 0, 9'h100, 9'h000, 0, 0));
    vecs.push_back(mk(2'd1, 9'h000, 9'h10A, 0, 0, 0, 9'h000, 9'h10A, 1, 0));
    vecs.push_back(mk(2'd1, 9'h000, 9'h000, 0, 1, 0, 9'h10A, 9'h000, 0, 0));
    vecs.push_back(mk(2'd1, 9'h000, 9'h020, 1, 0, 0, 9'h020, 9'h000, 0, 0));
    vecs.push_back(mk(2'd1, 9'h000, 9'h000, 1, 0, 0, 9'h000, 9'h000, 0, 0));
    vecs.push_back(mk(2'd1, 9'h000, 9'h003, 0, 0, 0, 9'h000, 9'h003, 1, 0));
    vecs.push_back(mk(2'd1, 9'h000, 9'h000, 1, 1, 0, 9'h003, 9'h000, 0, 0));
    vecs.push_back(mk(2'd2, 9'h010, 9'h014, 0, 0, 0, 9'h004, 9'h010, 1, 0));
    vecs.push_back(mk(2'd2, 9'h010, 9'h000, 0, 0, 0, 9'h000, 9'h010, 1, 0));
    vecs.push_back(mk(2'd2, 9'h010, 9'h000, 1, 0, 0, 9'h010, 9'h000, 0, 0));
    vecs.push_back(mk(2'd2, 9'h010, 9'h010, 0, 0, 0, 9'h000, 9'h010, 1, 0));
    vecs.push_back(mk(2'd2, 9'h000, 9'h000, 0, 0, 0, 9'h000, 9'h010, 1, 0));
    vecs.push_back(mk(2'd0, 9'h000, 9'h000, 0, 0, 0, 9'h010, 9'h000, 0, 0));
    vecs.push_back(mk(2'd1, 9'h000, 9'h020, 0, 0, 0, 9'h000, 9'h020, 1, 0));
    vecs.push_back(mk(2'd1, 9'h000, 9'h020, 0, 0, 0, 9'h000, 9'h020, 1, 1));
    vecs.push_back(mk(2'd1, 9'h000, 9'h000, 1, 0, 0, 9'h020, 9'h000, 0, 1));
    vecs.push_back(mk(2'd1, 9'h000, 9'h000, 0, 0, 1, 9'h000, 9'h000, 0, 0));
    vecs.push_back(mk(2'd3, 9'h000, 9'h001, 0, 0, 0, 9'h000, 9'h001, 1, 0));
    vecs.push_back(mk(2'd3, 9'h000, 9'h000, 0, 1, 0, 9'h001, 9'h000, 0, 0));

    foreach (vecs[k]) begin
      setIn(vecs[k].mode, vecs[k].bp, vecs[k].rdy, vecs[k].go, vecs[k].all, vecs[k].clr);
      doCycle();
      chk($sformatf("vec%0d_ready_out", k), 32'(ready_out), 32'(vecs[k].expOut));
      chk($sformatf("vec%0d_pending", k), 32'(pending), 32'(vecs[k].expPend));
      chk($sformatf("vec%0d_halted", k), 32'(halted), 32'(vecs[k].expHalt));
      chk($sformatf("vec%0d_overflow", k), 32'(overflow), 32'(vecs[k].expOvf));
    end

    // Saturation of the narrow counter after a clear.
    setIn(2'd0, '0, '0, 0, 0, 1);
    doCycle();
    chk("clr_step_count", 32'(step_count), 0);
    for (int k = 0; k < 5; k++) begin
      setIn(2'd0, '0, 9'h001, 0, 0, 0);
      doCycle();
    end
    chk("sat_small_count", 32'(stepCountS), 3);
    chk("wide_count_5", 32'(step_count), 5);

    // Reset while stage 0 is held discards it without a release.
    setIn(2'd1, '0, 9'h001, 0, 0, 0);
    doCycle();
    chk("hold_before_reset", 32'(pending), 1);
    reset = 1'b1;
    setIn(2'd1, '0, 9'h000, 1, 0, 0);
    doCycle();
    chk("reset_pending", 32'(pending), 0);
    chk("reset_no_release", 32'(ready_out), 0);
    reset = 1'b0;
    setIn(2'd1, '0, 9'h000, 1, 0, 0);
    doCycle();
    chk("after_reset_no_release", 32'(ready_out), 0);

    for (int k = 0; k < 2000; k++) begin
      reset = ($urandom_range(0, 99) == 0);
      mode = 2'($urandom_range(0, 3));
      bp_mask = 9'($urandom);
      ready_in = 9'($urandom) & 9'($urandom) & 9'($urandom);
      stage_done = 9'($urandom) & 9'($urandom);
      step_go = ($urandom_range(0, 3) == 0);
      step_all = ($urandom_range(0, 9) == 0);
      clr_status = ($urandom_range(0, 29) == 0);
      doCycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stage_step_gate.md
# stage_step_gate

Parametrised release gate between the encoder control FSM and the datapath pipe. It intercepts per-stage ready pulses from the FSM, holds them when the bench or debug host requests stepping, and releases them on command. It also aggregates per-stage done pulses into one registered `done_any` strobe. All state is registered, with no combinational feedback, and it generalises the fixed nine-stage test gating to N stages with bypass, single-step and breakpoint modes.

## Interface
- `NUM_STAGES`, default 9: number of gated stages (1..32).
- `CNT_W`, default 16: width of the release counter.

- `clock` in 1: single system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `mode` in 2: 00 bypass, 01 single-step (gate all stages), 10 breakpoint (gate only stages with a set `bp_mask` bit), 11 treated as 01.
- `bp_mask` in NUM_STAGES: breakpoint stage select, used in mode 10 only.
- `ready_in` in NUM_STAGES: one-cycle ready pulses from the FSM.
- `stage_done` in NUM_STAGES: one-cycle done pulses from the pipe.
- `step_go` in 1: release the lowest-indexed pending stage.
- `step_all` in 1: release every pending stage.
- `clr_status` in 1: clear `overflow` and `step_count`.
- `ready_out` out NUM_STAGES: registered ready pulses to the pipe.
- `pending` out NUM_STAGES: registered per-stage hold flags.
- `halted` out 1: registered, equals OR of next-state `pending`.
- `done_any` out 1: registered OR of `stage_done`.
- `overflow` out 1: sticky; a ready pulse arrived on a stage that was already pending.
- `step_count` out CNT_W: total released pulses, saturating at all-ones.

## Operation
- Gated set: `g = ~0` in modes 01/11, `g = bp_mask` in mode 10, `g = 0` in mode 00.
- Per cycle, compute the following:
  - `held = pending | (ready_in & g)`
  - `rel_sel = step_all ? held : lowest_set_bit(held)` when `step_go | step_all`, else 0
  - In mode 00: `rel_sel = pending`, which flushes all held pulses.
  - `release = rel_sel | (ready_in & ~g)`
- Register updates:
  - `ready_out <= release`
  - `pending <= held & ~rel_sel`
- Same-cycle `ready_in` and `step_go` on an idle gated stage: the stage is released directly and `pending` is never set.
- `step_go` with `held == 0` has no effect and is not queued.
- `step_go` and `step_all` together behave as `step_all`.
- Overflow: set when `ready_in[i] & pending[i] & g[i] & ~rel_sel[i]` for any i. The pulses merge and only one release is issued.
- Overflow ignores `clr_status` in a cycle where a new overflow occurs; set wins.
- `step_count <= sat(step_count + popcount(release))`. It stays at `2^CNT_W-1` once reached.
- `clr_status` zeroes `step_count`, and the same cycle's releases are not counted.
- Mode change takes effect combinationally on the cycle it is sampled. Leaving gated mode to 00 flushes `pending` in that cycle.
- In mode 10, clearing a `bp_mask` bit does not release that stage's pending flag. Only a step or mode 00 releases it.
- `done_any <= |stage_done`. It is independent of gating.

## Timing
- Reset: `ready_out=0`, `pending=0`, `halted=0`, `done_any=0`, `overflow=0`, `step_count=0`. Inputs are ignored in the reset cycle.
- Reset mid-hold discards pending pulses; no release is issued.
- Bypass latency is 1 cycle from `ready_in` to `ready_out`.
- Gated latency is 1 cycle from the releasing `step_go`/`step_all` edge to `ready_out`.
- `pending` and `halted` reflect a new hold 1 cycle after `ready_in`.
- `done_any` follows `stage_done` by 1 cycle.
- Every output is a single-cycle pulse per release. A stage never sees two `ready_out` pulses from one held request.

## Test plan
- Mode 00: `ready_in=9'h004` at cycle 5 -> `ready_out=9'h004` at cycle 6 only, `step_count=1`, `pending` stays 0.
- Mode 01: `ready_in=9'h001` at cycle 2, `step_go` at cycle 6 -> `pending[0]` set cycles 3..6, `ready_out=9'h001` at cycle 7, `halted` drops at cycle 7.
- Mode 01: pulses on stages 1, 3, 8 held; `step_go` three times -> releases occur in order 9'h002, 9'h008, 9'h100. Then a single `step_all` on a fresh identical set -> one cycle with `ready_out=9'h10A`, and `step_count` advances by 3.
- Mode 10 with `bp_mask=9'h010`: pulses on stages 2 and 4 -> stage 2 passes through after 1 cycle, stage 4 holds until `step_go`, and switching to mode 00 flushes it.
- Overflow: mode 01, two `ready_in[5]` pulses without a step -> `overflow=1`, a single release on `step_go`, and `clr_status` returns `overflow` and `step_count` to 0.
- `CNT_W=2`: five releases -> `step_count` saturates at 3. A reset asserted while stage 0 is pending -> all outputs 0 next cycle and no `ready_out` pulse.
